// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// state_e : arbiter FSM states
// owner_e : which requester holds the current memory access
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF       = 32;
   localparam int unsigned DATA_W_DEF       = 32;
   localparam int unsigned STARVE_LIMIT_DEF = 4;
   localparam int unsigned TIMEOUT_DEF      = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (LS).
// Latency: gnt same cycle as req in IDLE, mem_en from next cycle, rvalid one cycle after mem_ready (min 3 cycles/access).
// Backpressure: one access in flight; requests are only granted in IDLE, mem_ready stalls ACCESS up to TIMEOUT cycles.
//
// Ports: clk/rst_n (async active-low); if_req/if_addr -> if_gnt/if_rvalid/if_rdata;
//        ls_req/ls_we/ls_addr/ls_wdata -> ls_gnt/ls_rvalid/ls_rdata; bus_err qualifies rvalid;
//        mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata/mem_ready <- memory.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              bus_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_e            state_q;
   owner_e            owner_q;
   logic              we_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] ls_rdata_q;
   logic [SW-1:0]     starve_cnt_q;
   logic [TW-1:0]     tmo_cnt_q;

   logic              if_gnt_d;
   logic              ls_gnt_d;
   logic [DATA_W-1:0] resp_data_d;

   // LS normally wins; once IF has been passed over STARVE_LIMIT times in a row it gets the slot.
   always_comb begin
      if_gnt_d = 1'b0;
      ls_gnt_d = 1'b0;
      if (state_q == IDLE) begin
         if (ls_req && !(if_req && (starve_cnt_q == SW'(STARVE_LIMIT)))) begin
            ls_gnt_d = 1'b1;
         end else if (if_req) begin
            if_gnt_d = 1'b1;
         end
      end
   end

   // Stores return zero data; a timed-out access also returns zero.
   always_comb begin
      resp_data_d = '0;
      if (mem_ready && !we_q) begin
         resp_data_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IF;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         if_rdata_q   <= '0;
         ls_rdata_q   <= '0;
         starve_cnt_q <= '0;
         tmo_cnt_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ls_gnt_d) begin
                  owner_q   <= OWN_LS;
                  we_q      <= ls_we;
                  addr_q    <= ls_addr;
                  wdata_q   <= ls_wdata;
                  err_q     <= 1'b0;
                  tmo_cnt_q <= '0;
                  state_q   <= ACCESS;
                  if (!if_req) begin
                     starve_cnt_q <= '0;
                  end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
                     starve_cnt_q <= starve_cnt_q + SW'(1);
                  end
               end else if (if_gnt_d) begin
                  owner_q      <= OWN_IF;
                  we_q         <= 1'b0;
                  addr_q       <= if_addr;
                  wdata_q      <= '0;
                  err_q        <= 1'b0;
                  tmo_cnt_q    <= '0;
                  starve_cnt_q <= '0;
                  state_q      <= ACCESS;
               end
            end
            ACCESS: begin
               // tmo_cnt_q holds the number of ACCESS cycles already spent, so the
               // TIMEOUT-th cycle is tmo_cnt_q == TIMEOUT-1; ready on that cycle still succeeds.
               if (mem_ready || (tmo_cnt_q == TW'(TIMEOUT - 1))) begin
                  err_q   <= !mem_ready;
                  state_q <= RESP;
                  if (owner_q == OWN_LS) begin
                     ls_rdata_q <= resp_data_d;
                  end else begin
                     if_rdata_q <= resp_data_d;
                  end
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TW'(1);
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Grants are forced low while reset is held so every output reads 0 in reset.
   assign if_gnt    = if_gnt_d & rst_n;
   assign ls_gnt    = ls_gnt_d & rst_n;

   assign mem_en    = (state_q == ACCESS);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = mem_en ? addr_q  : '0;
   assign mem_wdata = mem_en ? wdata_q : '0;

   assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
   assign ls_rvalid = (state_q == RESP) && (owner_q == OWN_LS);
   assign bus_err   = (state_q == RESP) && err_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus multi-cycle sequences.
// Latency: n/a (bench).
// Backpressure: bench drives mem_ready directly to stall or time out accesses.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        if_req;
      logic [31:0] if_addr;
      logic        ls_req;
      logic        ls_we;
      logic [31:0] ls_addr;
      logic [31:0] ls_wdata;
      logic        mem_ready;
      logic [31:0] mem_rdata;
   } in_t;

   typedef struct packed {
      logic        if_gnt;
      logic        ls_gnt;
      logic        mem_en;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        if_rvalid;
      logic        ls_rvalid;
      logic        bus_err;
      logic [31:0] if_rdata;
      logic [31:0] ls_rdata;
   } out_t;

   typedef struct packed {
      in_t  in;
      out_t exp;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;
   logic        bus_err;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int n_vec;
   int n_err;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .bus_err(bus_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic in_t mk_in(logic ir, logic [31:0] ia, logic lr, logic lw,
                                 logic [31:0] la, logic [31:0] lwd, logic rdy, logic [31:0] rd);
      in_t v;
      v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw;
      v.ls_addr = la; v.ls_wdata = lwd; v.mem_ready = rdy; v.mem_rdata = rd;
      return v;
   endfunction

   function automatic out_t mk_out(logic ig, logic lg, logic en, logic we, logic [31:0] ma,
                                   logic [31:0] mw, logic iv, logic lv, logic be,
                                   logic [31:0] ird, logic [31:0] lrd);
      out_t v;
      v.if_gnt = ig; v.ls_gnt = lg; v.mem_en = en; v.mem_we = we; v.mem_addr = ma;
      v.mem_wdata = mw; v.if_rvalid = iv; v.ls_rvalid = lv; v.bus_err = be;
      v.if_rdata = ird; v.ls_rdata = lrd;
      return v;
   endfunction

   function automatic out_t sample();
      return mk_out(if_gnt, ls_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                    if_rvalid, ls_rvalid, bus_err, if_rdata, ls_rdata);
   endfunction

   task automatic apply(input in_t v);
      if_req = v.if_req; if_addr = v.if_addr; ls_req = v.ls_req; ls_we = v.ls_we;
      ls_addr = v.ls_addr; ls_wdata = v.ls_wdata; mem_ready = v.mem_ready; mem_rdata = v.mem_rdata;
   endtask

   task automatic check_out(input string name, input out_t exp);
      out_t act;
      act = sample();
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one access and follow it to its rvalid pulse (bounded); ready_at = ACCESS cycle
   // on which mem_ready is raised, 0 = never.
   task automatic run_access(input bit use_ls, input logic [31:0] addr, input int ready_at,
                             input logic [31:0] rd, output int en_cnt, output bit vld,
                             output bit err, output logic [31:0] data, output bit gnt_ok);
      @(posedge clk); #1;
      apply(mk_in(!use_ls, addr, use_ls, 1'b0, addr, 32'h0, 1'b0, 32'h0));
      #1;
      gnt_ok = use_ls ? (ls_gnt && !if_gnt) : (if_gnt && !ls_gnt);
      en_cnt = 0; vld = 1'b0; err = 1'b0; data = '0;
      for (int c = 0; c < 40 && !vld; c++) begin
         @(posedge clk); #1;
         if_req = 1'b0; ls_req = 1'b0;
         if_addr = 32'hFFFF_FFF0; ls_addr = 32'hFFFF_FFF0;
         mem_ready = (ready_at != 0) && (en_cnt + 1 == ready_at);
         mem_rdata = rd;
         #1;
         if (mem_en) en_cnt++;
         if (use_ls ? ls_rvalid : if_rvalid) begin
            vld = 1'b1; err = bus_err; data = use_ls ? ls_rdata : if_rdata;
         end
      end
      mem_ready = 1'b0;
   endtask

   initial begin
      vec_t  vecs[$];
      string grants;
      string exp_grants;
      int    en_cnt;
      bit    vld, err, gnt_ok, seen;
      logic [31:0] data;
      bit    last_ls;

      n_vec = 0; n_err = 0;
      rst_n = 1'b0;
      apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0));

      // ---------------- vector table: one row per clock cycle ----------------
      // single load, requester drops and changes inputs after grant
      vecs.push_back({mk_in(0,0,1,0,32'h100,0,0,0),           mk_out(0,1,0,0,0,0,0,0,0,0,0)});
      vecs.push_back({mk_in(0,0,0,0,32'h999,0,0,0),           mk_out(0,0,1,0,32'h100,0,0,0,0,0,0)});
      vecs.push_back({mk_in(0,0,0,0,32'h999,0,1,32'hDEADBEEF),mk_out(0,0,1,0,32'h100,0,0,0,0,0,0)});
      vecs.push_back({mk_in(0,0,0,0,0,0,0,0),                 mk_out(0,0,0,0,0,0,0,1,0,0,32'hDEADBEEF)});
      vecs.push_back({mk_in(0,0,0,0,0,0,0,0),                 mk_out(0,0,0,0,0,0,0,0,0,0,32'hDEADBEEF)});
      // store: rdata returned as 0 even though memory drives data
      vecs.push_back({mk_in(0,0,1,1,32'h40,32'h12345678,0,0), mk_out(0,1,0,0,0,0,0,0,0,0,32'hDEADBEEF)});
      vecs.push_back({mk_in(0,0,0,0,0,0,1,32'h55555555),      mk_out(0,0,1,1,32'h40,32'h12345678,0,0,0,0,32'hDEADBEEF)});
      vecs.push_back({mk_in(0,0,0,0,0,0,0,0),                 mk_out(0,0,0,0,0,0,0,1,0,0,0)});
      // fetch with address change after grant; no grant in ACCESS or RESP
      vecs.push_back({mk_in(1,32'h200,0,0,0,0,0,0),           mk_out(1,0,0,0,0,0,0,0,0,0,0)});
      vecs.push_back({mk_in(1,32'h204,0,0,0,0,0,0),           mk_out(0,0,1,0,32'h200,0,0,0,0,0,0)});
      vecs.push_back({mk_in(1,32'h204,0,0,0,0,1,32'hCAFE0001),mk_out(0,0,1,0,32'h200,0,0,0,0,0,0)});
      vecs.push_back({mk_in(1,32'h204,0,0,0,0,1,32'h77777777),mk_out(0,0,0,0,0,0,1,0,0,32'hCAFE0001,0)});
      vecs.push_back({mk_in(1,32'h204,0,0,0,0,0,0),           mk_out(1,0,0,0,0,0,0,0,0,32'hCAFE0001,0)});
      vecs.push_back({mk_in(0,0,0,0,0,0,1,32'h11112222),      mk_out(0,0,1,0,32'h204,0,0,0,0,32'hCAFE0001,0)});
      vecs.push_back({mk_in(0,0,0,0,0,0,0,0),                 mk_out(0,0,0,0,0,0,1,0,0,32'h11112222,0)});
      // mem_ready in IDLE is ignored
      vecs.push_back({mk_in(0,0,0,0,0,0,1,32'h99),            mk_out(0,0,0,0,0,0,0,0,0,32'h11112222,0)});
      // both request: LS wins, IF served next
      vecs.push_back({mk_in(1,32'h300,1,0,32'h400,0,0,0),     mk_out(0,1,0,0,0,0,0,0,0,32'h11112222,0)});
      vecs.push_back({mk_in(1,32'h300,0,0,0,0,1,32'hABCD0000),mk_out(0,0,1,0,32'h400,0,0,0,0,32'h11112222,0)});
      vecs.push_back({mk_in(1,32'h300,0,0,0,0,0,0),           mk_out(0,0,0,0,0,0,0,1,0,32'h11112222,32'hABCD0000)});
      vecs.push_back({mk_in(1,32'h300,0,0,0,0,0,0),           mk_out(1,0,0,0,0,0,0,0,0,32'h11112222,32'hABCD0000)});
      vecs.push_back({mk_in(0,0,0,0,0,0,1,32'h42),            mk_out(0,0,1,0,32'h300,0,0,0,0,32'h11112222,32'hABCD0000)});
      vecs.push_back({mk_in(0,0,0,0,0,0,0,0),                 mk_out(0,0,0,0,0,0,1,0,0,32'h42,32'hABCD0000)});

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #2;
      check_out("reset_state", mk_out(0,0,0,0,0,0,0,0,0,0,0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check_out("after_release", mk_out(0,0,0,0,0,0,0,0,0,0,0));

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         apply(vecs[i].in);
         #1;
         check_out($sformatf("vec%0d", i), vecs[i].exp);
      end

      // ---------------- contention: both held, expect LS x4 then IF ----------------
      @(posedge clk); #1;
      apply(mk_in(1, 32'h800, 1, 0, 32'h900, 0, 1, 32'h5A5A5A5A));
      grants = ""; last_ls = 1'b0;
      exp_grants = "LLLLILLLLI";
      for (int c = 0; c < 80 && grants.len() < 10; c++) begin
         if (c != 0) begin
            @(posedge clk); #1;
         end
         #1;
         if (if_gnt && ls_gnt) chk($sformatf("double_gnt_c%0d", c), 64'(if_gnt & ls_gnt), 64'd0);
         if (if_rvalid || ls_rvalid) chk($sformatf("rvalid_owner_c%0d", c), 64'(ls_rvalid), 64'(last_ls));
         if (ls_gnt) begin grants = {grants, "L"}; last_ls = 1'b1; end
         else if (if_gnt) begin grants = {grants, "I"}; last_ls = 1'b0; end
      end
      chk("grant_count", 64'(grants.len()), 64'd10);
      for (int g = 0; g < 10; g++) begin
         if (g < grants.len()) chk($sformatf("grant%0d", g), 64'(grants[g]), 64'(exp_grants[g]));
      end
      @(posedge clk); #1;
      apply(mk_in(0, 0, 0, 0, 0, 0, 1, 0));
      repeat (4) @(posedge clk);
      #1;
      mem_ready = 1'b0;

      // ---------------- timeout, recovery, ready on the last allowed cycle ----------------
      run_access(1'b1, 32'h500, 0, 32'hBAD0BAD0, en_cnt, vld, err, data, gnt_ok);
      chk("tmo_gnt", 64'(gnt_ok), 64'd1);
      chk("tmo_rvalid", 64'(vld), 64'd1);
      chk("tmo_en_cycles", 64'(en_cnt), 64'd16);
      chk("tmo_bus_err", 64'(err), 64'd1);

      run_access(1'b1, 32'h504, 1, 32'h600D600D, en_cnt, vld, err, data, gnt_ok);
      chk("post_tmo_rvalid", 64'(vld), 64'd1);
      chk("post_tmo_en_cycles", 64'(en_cnt), 64'd1);
      chk("post_tmo_bus_err", 64'(err), 64'd0);
      chk("post_tmo_data", 64'(data), 64'h600D600D);

      run_access(1'b0, 32'h508, 16, 32'h0000F00D, en_cnt, vld, err, data, gnt_ok);
      chk("edge_gnt", 64'(gnt_ok), 64'd1);
      chk("edge_rvalid", 64'(vld), 64'd1);
      chk("edge_en_cycles", 64'(en_cnt), 64'd16);
      chk("edge_bus_err", 64'(err), 64'd0);
      chk("edge_data", 64'(data), 64'h0000F00D);

      run_access(1'b0, 32'h50C, 3, 32'h13579BDF, en_cnt, vld, err, data, gnt_ok);
      chk("stall3_en_cycles", 64'(en_cnt), 64'd3);
      chk("stall3_data", 64'(data), 64'h13579BDF);

      // ---------------- reset in the middle of an access ----------------
      @(posedge clk); #1;
      apply(mk_in(0, 0, 1, 1, 32'h700, 32'hA5A5A5A5, 0, 0));
      @(posedge clk); #1;
      apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      check_out("pre_reset_access", mk_out(0,0,1,1,32'h700,32'hA5A5A5A5,0,0,0,32'h13579BDF,32'h600D600D));
      #1;
      rst_n = 1'b0;
      #1;
      check_out("mid_access_reset", mk_out(0,0,0,0,0,0,0,0,0,0,0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (if_rvalid || ls_rvalid || mem_en) seen = 1'b1;
      end
      chk("no_rvalid_after_reset", 64'(seen), 64'd0);
      mem_ready = 1'b0;

      run_access(1'b1, 32'h710, 2, 32'h2468ACE0, en_cnt, vld, err, data, gnt_ok);
      chk("after_reset_rvalid", 64'(vld), 64'd1);
      chk("after_reset_data", 64'(data), 64'h2468ACE0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
